// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// The master side supplies words; the slave side is the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             sdo;
  logic             frame;
  logic             done;

  modport master (
    output load_data, load_valid,
    input  load_ready, sdo, frame, done
  );

  modport slave (
    input  load_data, load_valid,
    output load_ready, sdo, frame, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding a falling-edge flip-flop; all state moves on negedge cn.
// Define PARITY_EN to append an even-parity symbol after the data bits (WIDTH+1 symbols per frame).
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              cn,
  input  logic              rn,
  piso_serializer_if.slave  bus
);

`ifdef PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             sdo_q;
  logic             frame_q;
  logic             done_q;

  logic             last_sym;
  logic             handshake;
  logic             first_bit;
  logic             next_bit;
  logic             next_sym;
  logic [WIDTH-1:0] load_shifted;
  logic [WIDTH-1:0] shreg_shifted;

  assign last_sym       = (state == ST_SHIFT) && (cnt == LAST_CNT);
  assign bus.load_ready = (state == ST_IDLE) || last_sym;
  assign handshake      = bus.load_valid && bus.load_ready;

  // Symbol 0 goes straight to sdo on the load edge; shreg keeps only the bits still to send.
  // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    if (LSB_FIRST) begin
      first_bit     = bus.load_data[0];
      load_shifted  = bus.load_data >> 1;
      next_bit      = shreg[0];
      shreg_shifted = shreg >> 1;
    end else begin
      first_bit     = bus.load_data[WIDTH-1];
      load_shifted  = bus.load_data << 1;
      next_bit      = shreg[WIDTH-1];
      shreg_shifted = shreg << 1;
    end
  end

`ifdef PARITY_EN
  logic parity_q;

  always_ff @(negedge cn or negedge rn) begin
    if (!rn) begin
      parity_q <= 1'b0;
    end else if (handshake) begin
      parity_q <= ^bus.load_data;
    end
  end

  // After the last data bit the parity symbol is emitted instead of a shifted bit.
  assign next_sym = (cnt == CNT_W'(WIDTH - 1)) ? parity_q : next_bit;
`else
  assign next_sym = next_bit;
`endif

  // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
  always_ff @(negedge cn or negedge rn) begin
    if (!rn) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      cnt     <= '0;
      sdo_q   <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (handshake) begin
      state   <= ST_SHIFT;
      shreg   <= load_shifted;
      cnt     <= '0;
      sdo_q   <= first_bit;
      frame_q <= 1'b1;
      done_q  <= last_sym;  // back-to-back reload still reports the end of the previous frame
    end else if (state == ST_SHIFT) begin
      if (last_sym) begin
        state   <= ST_IDLE;
        shreg   <= '0;
        cnt     <= '0;
        sdo_q   <= 1'b0;
        frame_q <= 1'b0;
        done_q  <= 1'b1;
      end else begin
        shreg   <= shreg_shifted;
        cnt     <= cnt + CNT_W'(1);
        sdo_q   <= next_sym;
        frame_q <= 1'b1;
        done_q  <= 1'b0;
      end
    end else begin
      sdo_q   <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end
  end

  assign bus.sdo   = sdo_q;
  assign bus.frame = frame_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: an LSB-first and an MSB-first instance share one load stream,
// each checked against a symbol queue built from the loaded words.
module tb_piso_serializer;
  localparam int W = 8;
`ifdef PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif

  typedef struct packed {
    logic val;
    logic last;
  } sym_t;

  logic         cn = 1'b1;
  logic         rn = 1'b0;
  logic         load_valid;
  logic [W-1:0] load_data;

  int   checks = 0;
  int   errors = 0;
  sym_t sb [2][$];
  logic prev_last [2] = '{1'b0, 1'b0};

  logic obs_sdo   [2];
  logic obs_frame [2];
  logic obs_done  [2];
  logic obs_ready [2];

  piso_serializer_if #(.WIDTH(W)) if_lsb ();
  piso_serializer_if #(.WIDTH(W)) if_msb ();

  assign if_lsb.load_valid = load_valid;
  assign if_lsb.load_data  = load_data;
  assign if_msb.load_valid = load_valid;
  assign if_msb.load_data  = load_data;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (.cn(cn), .rn(rn), .bus(if_lsb));
  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (.cn(cn), .rn(rn), .bus(if_msb));

  assign obs_sdo[0]   = if_lsb.sdo;
  assign obs_frame[0] = if_lsb.frame;
  assign obs_done[0]  = if_lsb.done;
  assign obs_ready[0] = if_lsb.load_ready;
  assign obs_sdo[1]   = if_msb.sdo;
  assign obs_frame[1] = if_msb.frame;
  assign obs_done[1]  = if_msb.done;
  assign obs_ready[1] = if_msb.load_ready;

  always #5 cn = ~cn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected symbol stream of one frame for each bit order, parity last when enabled.
  task automatic push_word(input logic [W-1:0] w);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        sym_t s;
        if (i < W) s.val = (d == 0) ? w[i] : w[W-1-i];
        else       s.val = ^w;
        s.last = (i == N - 1);
        sb[d].push_back(s);
      end
    end
  endtask

  // Holds load_valid until the model says the serializer is ready, then pushes the word.
  task automatic send(input logic [W-1:0] w, input bit churn);
    int guard = 0;
    load_valid = 1'b1;
    load_data  = w;
    while (sb[0].size() != 0) begin
      if (churn) load_data = W'($urandom);
      @(posedge cn); #1;
      guard++;
      if (guard > 4 * N) begin
        check("send_timeout", guard, 0);
        return;
      end
    end
    load_data = w;
    push_word(w);
    @(posedge cn); #1;
  endtask

  task automatic idle(input int n);
    load_valid = 1'b0;
    repeat (n) begin
      @(posedge cn); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_sdo[%0d]", tag, d),   obs_sdo[d],   0);
      check($sformatf("%s_frame[%0d]", tag, d), obs_frame[d], 0);
      check($sformatf("%s_done[%0d]", tag, d),  obs_done[d],  0);
      check($sformatf("%s_ready[%0d]", tag, d), obs_ready[d], 1);
    end
  endtask

  // Monitor: one expected symbol (or idle) per falling edge, sampled on the rising edge.
  initial begin
    forever begin
      @(posedge cn);
      for (int d = 0; d < 2; d++) begin
        sym_t s;
        logic e_sdo;
        logic e_frame;
        logic e_done;
        e_done = prev_last[d];
        if (sb[d].size() != 0) begin
          s            = sb[d].pop_front();
          e_sdo        = s.val;
          e_frame      = 1'b1;
          prev_last[d] = s.last;
        end else begin
          e_sdo        = 1'b0;
          e_frame      = 1'b0;
          prev_last[d] = 1'b0;
        end
        check($sformatf("sdo[%0d]", d),   obs_sdo[d],   e_sdo);
        check($sformatf("frame[%0d]", d), obs_frame[d], e_frame);
        check($sformatf("done[%0d]", d),  obs_done[d],  e_done);
        check($sformatf("ready[%0d]", d), obs_ready[d], sb[d].size() == 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    load_valid = 1'b0;
    load_data  = '0;
    #2;
    check_reset_outputs("por");
    @(posedge cn); #1;
    rn = 1'b1;

    // Single frame in both bit orders, then its DONE pulse.
    send(8'hA5, 1'b0);
    idle(N + 2);

    // Back-to-back with valid held across the frame boundary.
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    idle(N + 2);

    // New word offered mid-frame must wait for the last-symbol cycle.
    send(8'hA5, 1'b0);
    idle(2);
    send(8'h3C, 1'b0);
    idle(N + 2);

    // Parity-relevant words (odd and even weight).
    send(8'h07, 1'b0);
    idle(N + 2);
    send(8'hA5, 1'b0);
    idle(N + 2);

    // Asynchronous reset mid-frame, checked between clock edges.
    send(8'hC3, 1'b0);
    idle(3);
    #2;
    rn = 1'b0;
    #1;
    check_reset_outputs("abort");
    sb[0].delete();
    sb[1].delete();
    prev_last[0] = 1'b0;
    prev_last[1] = 1'b0;
    @(posedge cn); #1;
    rn = 1'b1;
    send(8'h5A, 1'b0);
    idle(N + 2);

    // Continuous valid: frames repeat every N cycles.
    repeat (6) send(W'($urandom), 1'b0);
    idle(N + 2);

    // Random words, gaps and data churn while not ready.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      send(W'($urandom), 1'($urandom_range(0, 1)));
    end
    idle(N + 3);

    check("scoreboard_drained", sb[0].size() + sb[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
